// File: rtl/conv_window_generator_pkg.sv
// Shared types and sizing helpers for the convolution window generator.
package conv_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_IMG_WIDTH   = 28;
  localparam int DEF_IMG_HEIGHT  = 28;
  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_D_WIDTH     = 8;
  localparam int DEF_COL_W       = $clog2(DEF_IMG_WIDTH);
  localparam int DEF_ROW_W       = $clog2(DEF_IMG_HEIGHT);

  function automatic int win_elems(input int k);
    return k * k;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_window_generator_if.sv
// Pixel-in / window-out handshake bundle. In/sof and err_sync exist only
// when CONV_WINDOW_SYNC_EN is defined.
interface conv_window_generator_if
  import conv_pkg::*;
#(
  parameter int D_WIDTH     = DEF_D_WIDTH,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
);
  localparam int OUT_W = D_WIDTH * win_elems(KERNEL_SIZE);

  logic               in_valid;
  logic               in_ready;
  logic [D_WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic               out_last;
`ifdef CONV_WINDOW_SYNC_EN
  logic               in_sof;
  logic               err_sync;

  modport master (output in_valid, in_data, in_sof, out_ready,
                  input  in_ready, out_valid, out_data, out_last, err_sync);
  modport slave  (input  in_valid, in_data, in_sof, out_ready,
                  output in_ready, out_valid, out_data, out_last, err_sync);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_last);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_last);
`endif
endinterface

// File: rtl/conv_window_generator_line_buffer.sv
// One image-row delay: q is the pixel accepted DEPTH enables earlier.
module line_buffer #(
  parameter int DEPTH   = 28,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               en,
  input  logic [D_WIDTH-1:0] d,
  output logic [D_WIDTH-1:0] q
);
  logic [D_WIDTH-1:0] mem_q [DEPTH];

  // Shift register advanced only on accepted pixels; contents are not reset.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign q = mem_q[DEPTH-1];
endmodule

// File: rtl/conv_window_generator.sv
// Streaming KxK window generator over a raster pixel stream.
// Optional frame resync via macro CONV_WINDOW_SYNC_EN (adds in_sof / err_sync).
module conv_window_generator
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int D_WIDTH     = DEF_D_WIDTH
) (
  input logic                    clk,
  input logic                    rst_n,
  conv_window_generator_if.slave win_if
);
  localparam int COL_W = cnt_w(IMG_WIDTH);
  localparam int ROW_W = cnt_w(IMG_HEIGHT);
  localparam int K     = KERNEL_SIZE;
  localparam int OUT_W = D_WIDTH * win_elems(K);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_EMIT  = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_PRIME = ROW_W'(K - 2);

  state_e             state_q, state_d, pos_state_s;
  logic [COL_W-1:0]   col_q, col_d, pos_col_s;
  logic [ROW_W-1:0]   row_q, row_d, pos_row_s;
  logic               accept_s, resync_s, emit_s, last_s;
  logic               out_valid_q, out_last_q;
  logic [OUT_W-1:0]   out_data_q, win_flat_s;
  logic [D_WIDTH-1:0] lb_q  [K-1];
  logic [D_WIDTH-1:0] tap_s [K];
  logic [D_WIDTH-1:0] win_q [K][K];
  logic [D_WIDTH-1:0] win_d [K][K];

  assign win_if.in_ready  = !out_valid_q || win_if.out_ready;
  assign accept_s         = win_if.in_valid && win_if.in_ready;
  assign win_if.out_valid = out_valid_q;
  assign win_if.out_data  = out_data_q;
  assign win_if.out_last  = out_last_q;

`ifdef CONV_WINDOW_SYNC_EN
  logic err_sync_q;
  logic at_origin_s;
  assign resync_s        = accept_s && win_if.in_sof;
  assign at_origin_s     = (col_q == '0) && (row_q == '0);
  assign win_if.err_sync = err_sync_q;

  // Sticky flag: a start-of-frame marker disagrees with the free-running position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sync_q <= 1'b0;
    end else if (accept_s && (win_if.in_sof != at_origin_s)) begin
      err_sync_q <= 1'b1;
    end
  end
`else
  assign resync_s = 1'b0;
`endif

  // Effective position of the current beat; a resync beat counts as pixel (0,0).
  always_comb begin
    if (resync_s) begin
      pos_col_s   = '0;
      pos_row_s   = '0;
      pos_state_s = FILL;
    end else begin
      pos_col_s   = col_q;
      pos_row_s   = row_q;
      pos_state_s = state_q;
    end
  end

  genvar j;
  for (j = 0; j < K - 1; j++) begin : g_lb
    logic [D_WIDTH-1:0] lb_d;
    if (j == 0) begin : g_head
      assign lb_d = win_if.in_data;
    end else begin : g_chain
      assign lb_d = lb_q[j-1];
    end
    line_buffer #(.DEPTH(IMG_WIDTH), .D_WIDTH(D_WIDTH)) u_lb (
      .clk (clk),
      .en  (accept_s),
      .d   (lb_d),
      .q   (lb_q[j])
    );
    // Row K-2-j of the new column comes from the j-th delay stage.
    assign tap_s[K-2-j] = lb_q[j];
  end
  assign tap_s[K-1] = win_if.in_data;

  // Window after this beat: shift left, new column on the right, then flatten.
  always_comb begin
    win_flat_s = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
      win_d[r][K-1] = tap_s[r];
      for (int c = 0; c < K; c++) begin
        win_flat_s[D_WIDTH*(r*K+c) +: D_WIDTH] = win_d[r][c];
      end
    end
  end

  // Window storage, intentionally without reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      win_q <= win_d;
    end
  end

  // Raster position of the next pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept_s) begin
      if (pos_col_s == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row_s == ROW_LAST) ? '0 : pos_row_s + ROW_W'(1);
      end else begin
        col_d = pos_col_s + COL_W'(1);
        row_d = pos_row_s;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // State and position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // FILL primes the line buffers; RUN emits windows until the frame ends.
  always_comb begin
    state_d = pos_state_s;
    case (pos_state_s)
      FILL: begin
        if (accept_s && (pos_row_s == ROW_PRIME) && (pos_col_s == COL_LAST)) begin
          state_d = RUN;
        end else begin
          state_d = FILL;
        end
      end
      RUN: begin
        if (accept_s && (pos_row_s == ROW_LAST) && (pos_col_s == COL_LAST)) begin
          state_d = FILL;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Emission decode for the current beat.
  always_comb begin
    emit_s = 1'b0;
    last_s = 1'b0;
    if (accept_s && (pos_state_s == RUN) && (pos_col_s >= COL_EMIT)) begin
      emit_s = 1'b1;
      last_s = (pos_row_s == ROW_LAST) && (pos_col_s == COL_LAST);
    end else begin
      emit_s = 1'b0;
      last_s = 1'b0;
    end
  end

  // Single output stage: load on emit, drop valid on a handshake with nothing new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (emit_s) begin
      out_valid_q <= 1'b1;
      out_last_q  <= last_s;
      out_data_q  <= win_flat_s;
    end else if (win_if.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
